// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
//   Computes one fully-connected layer with a single time-shared MAC.
//   For each output neuron n it streams N_IN activation/weight pairs from
//   synchronous (1-cycle latency) memories, adds the neuron's bias and
//   presents the result on a valid/ready output. Each neuron takes N_IN+3
//   cycles when the consumer is always ready.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            begin a layer pass (sampled only while idle)
//   busy             high while a pass is in progress (low in the done cycle)
//   in_addr/in_data  activation memory read port, data 1 cycle after address
//   w_addr/w_data    weight memory read port, address n*N_IN+k
//   b_addr/b_data    bias memory read port, address n
//   out_valid/out_ready/out_data/out_idx
//                    one result per neuron, held while out_ready is low
//   done             one-cycle pulse at the end of the pass
module fc_layer_sequencer #(
  parameter int N_IN  = 3136,
  parameter int N_OUT = 10,
  parameter int IN_W  = 30,
  parameter int W_W   = 9,
  parameter int ACC_W = 38,
  localparam int IA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [IA_W-1:0]         in_addr,
  input  logic signed [IN_W-1:0]  in_data,
  output logic [WA_W-1:0]         w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic [BA_W-1:0]         b_addr,
  input  logic signed [W_W-1:0]   b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [BA_W-1:0]         out_idx,
  output logic                    done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [IA_W-1:0] K_LAST = IA_W'(N_IN - 1);
  localparam logic [IA_W-1:0] K_ONE  = IA_W'(1);
  localparam logic [BA_W-1:0] N_LAST = BA_W'(N_OUT - 1);

  logic [2:0]             state_q, state_d;
  logic [IA_W-1:0]        k_q, k_d;
  logic [BA_W-1:0]        n_q, n_d;
  logic [WA_W-1:0]        w_addr_q, w_addr_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic signed [W_W-1:0]  bias_q, bias_d;
  logic [ACC_W-1:0]       out_data_q, out_data_d;
  logic [BA_W-1:0]        out_idx_q, out_idx_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q, done_d;

  logic [ACC_W-1:0]       prod;
  logic [ACC_W-1:0]       bias_ext;

  // The product is only ever used modulo 2^ACC_W, so multiplying the
  // sign-extended operands at ACC_W bits gives exactly the truncated (or
  // sign-extended) IN_W+W_W-bit product.
  assign prod     = ACC_W'(in_data) * ACC_W'(w_data);
  assign bias_ext = ACC_W'(bias_q);

  always_comb begin
    // NOTE: every combinational output gets a default here so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    w_addr_d   = w_addr_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_MAC;
          k_d      = '0;
          n_d      = '0;
          w_addr_d = '0;
          acc_d    = '0;
        end
      end

      S_MAC: begin
        // Memory data lags the address by one cycle, so the first MAC
        // cycle has nothing to accumulate yet.
        if (k_q != '0) acc_d = acc_q + prod;
        // b_addr has been stable since the k=0 cycle.
        if (k_q == K_ONE) bias_d = b_data;
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end

      S_DRAIN: begin
        acc_d = acc_q + prod;
        // With a single input there is no k=1 cycle; the bias word is
        // still on b_data here because b_addr has not moved.
        if (N_IN == 1) bias_d = b_data;
        state_d = S_BIAS;
      end

      S_BIAS: begin
        acc_d      = acc_q + bias_ext;
        out_data_d = acc_q + bias_ext;
        out_idx_d  = n_q;
        state_d    = S_WRITE;
      end

      S_WRITE: begin
        if (out_ready) begin
          if (n_q != N_LAST) begin
            n_d      = n_q + 1'b1;
            k_d      = '0;
            acc_d    = '0;
            // w_addr sits at n*N_IN+N_IN-1, so +1 is the next neuron's base.
            w_addr_d = w_addr_q + 1'b1;
            state_d  = S_MAC;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_comb begin
    busy_d      = (state_d == S_MAC) || (state_d == S_DRAIN) ||
                  (state_d == S_BIAS) || (state_d == S_WRITE);
    out_valid_d = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  // NOTE: the accumulator and bias are datapath registers but are still
  // reset, so an aborted pass leaves no stale partial sum behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      w_addr_q    <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      w_addr_q    <= w_addr_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // k and n double as the activation and bias addresses; they are
  // registers, so the addresses hold their last value outside MAC.
  assign in_addr   = k_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = n_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
`timescale 1ns/1ps
module tb_fc_layer_sequencer;

  localparam int IN_W   = 30;
  localparam int W_W    = 9;
  localparam int ACC_W  = 38;
  localparam int S_NIN  = 4;
  localparam int S_NOUT = 2;
  localparam int B_NIN  = 3136;
  localparam int B_NOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]              idx;
    logic signed [ACC_W-1:0] data;
    int                      cyc;
  } exp_t;
  exp_t sb[$];

  // ---------------- small instance (N_IN=4, N_OUT=2) ----------------
  logic                    s_start = 1'b0, s_out_ready = 1'b1;
  logic                    s_busy, s_out_valid, s_done;
  logic [1:0]              s_in_addr;
  logic [2:0]              s_w_addr;
  logic [0:0]              s_b_addr, s_out_idx;
  logic signed [IN_W-1:0]  s_in_data;
  logic signed [W_W-1:0]   s_w_data, s_b_data;
  logic signed [ACC_W-1:0] s_out_data;

  logic signed [IN_W-1:0]  s_in_mem [S_NIN];
  logic signed [W_W-1:0]   s_w_mem  [S_NIN*S_NOUT];
  logic signed [W_W-1:0]   s_b_mem  [S_NOUT];

  always @(posedge clk) begin
    s_in_data <= s_in_mem[s_in_addr];
    s_w_data  <= s_w_mem[s_w_addr];
    s_b_data  <= s_b_mem[s_b_addr];
  end

  fc_layer_sequencer #(.N_IN(S_NIN), .N_OUT(S_NOUT), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy),
    .in_addr(s_in_addr), .in_data(s_in_data),
    .w_addr(s_w_addr), .w_data(s_w_data),
    .b_addr(s_b_addr), .b_data(s_b_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_idx(s_out_idx), .done(s_done)
  );

  // ---------------- default instance (N_IN=3136, N_OUT=10) ----------------
  logic                    b_start = 1'b0, b_out_ready = 1'b1;
  logic                    b_busy, b_out_valid, b_done;
  logic [11:0]             b_in_addr;
  logic [14:0]             b_w_addr;
  logic [3:0]              b_b_addr, b_out_idx;
  logic signed [IN_W-1:0]  b_in_data;
  logic signed [W_W-1:0]   b_w_data, b_b_data;
  logic signed [ACC_W-1:0] b_out_data;

  function automatic logic signed [IN_W-1:0] big_in(input int a);
    return IN_W'((a % 7) - 3);
  endfunction
  function automatic logic signed [W_W-1:0] big_w(input int a);
    return W_W'((a % 5) - 2);
  endfunction
  function automatic logic signed [W_W-1:0] big_b(input int n);
    return W_W'(n - 4);
  endfunction

  always @(posedge clk) begin
    b_in_data <= big_in(int'(b_in_addr));
    b_w_data  <= big_w(int'(b_w_addr));
    b_b_data  <= big_b(int'(b_b_addr));
  end

  fc_layer_sequencer dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
    .in_addr(b_in_addr), .in_data(b_in_data),
    .w_addr(b_w_addr), .w_data(b_w_data),
    .b_addr(b_b_addr), .b_data(b_b_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .done(b_done)
  );

  // ---------------- reference models ----------------
  function automatic logic signed [ACC_W-1:0] small_model(input int n);
    longint sum = 0;
    for (int k = 0; k < S_NIN; k++)
      sum += longint'(s_in_mem[k]) * longint'(s_w_mem[n*S_NIN + k]);
    sum += longint'(s_b_mem[n]);
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] big_model(input int n);
    longint sum = 0;
    for (int k = 0; k < B_NIN; k++)
      sum += longint'(big_in(k)) * longint'(big_w(n*B_NIN + k));
    sum += longint'(big_b(n));
    return sum[ACC_W-1:0];
  endfunction

  task automatic load_basic();
    for (int k = 0; k < S_NIN; k++) s_in_mem[k] = IN_W'(k + 1);
    for (int k = 0; k < S_NIN; k++) s_w_mem[k] = 9'sd1;
    s_w_mem[4] = -9'sd1; s_w_mem[5] = 9'sd2; s_w_mem[6] = -9'sd3; s_w_mem[7] = 9'sd4;
    s_b_mem[0] = 9'sd5;  s_b_mem[1] = -9'sd2;
  endtask

  task automatic push_exp(input int idx, input logic signed [ACC_W-1:0] data, input int cyc);
    exp_t e;
    e.idx = 4'(idx); e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Runs one small pass: start is sampled at the edge ending cycle 0, and
  // each later cycle c is driven then observed at its falling edge.
  task automatic run_small(input int bp_from, input int bp_len, input bit glitch,
                           input int exp_done, input string tag);
    int  done_cnt = 0;
    int  res_cnt  = 0;
    bit  exp_valid;
    @(negedge clk);
    s_start = 1'b1; s_out_ready = 1'b1;
    for (int c = 1; c <= exp_done + 8; c++) begin
      @(negedge clk);
      s_start     = glitch && (c == 2 || c == 9);
      s_out_ready = !(c >= bp_from && c < bp_from + bp_len);
      total++;
      if (s_busy !== (c < exp_done)) begin
        bad++; $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, s_busy, (c < exp_done));
      end
      total++;
      if (s_done !== (c == exp_done)) begin
        bad++; $display("FAIL %s done c=%0d: got %b expected %b", tag, c, s_done, (c == exp_done));
      end
      if (s_done === 1'b1) done_cnt++;
      exp_valid = (sb.size() > 0) && (c >= sb[0].cyc);
      total++;
      if (s_out_valid !== exp_valid) begin
        bad++; $display("FAIL %s out_valid c=%0d: got %b expected %b", tag, c, s_out_valid, exp_valid);
      end
      if (s_out_valid === 1'b1 && exp_valid) begin
        total++;
        if (s_out_data !== sb[0].data || s_out_idx !== sb[0].idx[0:0]) begin
          bad++; $display("FAIL %s result c=%0d: got idx=%0d data=%0d expected idx=%0d data=%0d",
                          tag, c, s_out_idx, s_out_data, sb[0].idx, sb[0].data);
        end
        if (s_out_ready) begin
          void'(sb.pop_front());
          res_cnt++;
        end
      end
    end
    s_start = 1'b0; s_out_ready = 1'b1;
    total++;
    if (res_cnt != S_NOUT || done_cnt != 1 || sb.size() != 0) begin
      bad++; $display("FAIL %s counts: got results=%0d dones=%0d left=%0d expected %0d/1/0",
                      tag, res_cnt, done_cnt, sb.size(), S_NOUT);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if ({s_busy, s_out_valid, s_done, s_out_data, s_out_idx, s_in_addr, s_w_addr, s_b_addr} !== '0) begin
      bad++; $display("FAIL reset_small: got busy=%b ov=%b done=%b data=%0d idx=%0d ia=%0d wa=%0d ba=%0d expected all 0",
                      s_busy, s_out_valid, s_done, s_out_data, s_out_idx, s_in_addr, s_w_addr, s_b_addr);
    end
    total++;
    if ({b_busy, b_out_valid, b_done, b_out_data, b_in_addr, b_w_addr, b_b_addr} !== '0) begin
      bad++; $display("FAIL reset_big: outputs not all zero");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic();
    push_exp(0, small_model(0), 7);
    push_exp(1, small_model(1), 14);
    total++;
    if (small_model(0) !== 38'sd15 || small_model(1) !== 38'sd8) begin
      bad++; $display("FAIL model_basic: got %0d %0d expected 15 8", small_model(0), small_model(1));
    end
    run_small(0, 0, 1'b0, 15, "basic");
  endtask

  task automatic test_backpressure();
    load_basic();
    push_exp(0, 38'sd15, 7);
    push_exp(1, 38'sd8, 19);
    run_small(7, 5, 1'b0, 20, "backpressure");
  endtask

  task automatic test_wrap();
    for (int k = 0; k < S_NIN; k++) s_in_mem[k] = IN_W'(-(longint'(1) << 29));
    for (int k = 0; k < S_NIN*S_NOUT; k++) s_w_mem[k] = -9'sd256;
    s_b_mem[0] = '0; s_b_mem[1] = '0;
    push_exp(0, '0, 7);
    push_exp(1, '0, 14);
    run_small(0, 0, 1'b0, 15, "wrap");
  endtask

  task automatic test_reset_midpass();
    load_basic();
    @(negedge clk);
    s_start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      s_start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({s_busy, s_out_valid, s_done, s_out_data, s_out_idx, s_in_addr, s_w_addr, s_b_addr} !== '0) begin
      bad++; $display("FAIL midpass_reset: got busy=%b ov=%b done=%b ia=%0d wa=%0d expected all 0",
                      s_busy, s_out_valid, s_done, s_in_addr, s_w_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (s_out_valid !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b0) begin
        bad++; $display("FAIL after_abort c=%0d: got ov=%b done=%b busy=%b expected 0 0 0",
                        c, s_out_valid, s_done, s_busy);
      end
    end
    push_exp(0, 38'sd15, 7);
    push_exp(1, 38'sd8, 14);
    run_small(0, 0, 1'b0, 15, "restart");
  endtask

  task automatic test_start_ignored();
    load_basic();
    push_exp(0, 38'sd15, 7);
    push_exp(1, 38'sd8, 14);
    run_small(0, 0, 1'b1, 15, "start_ignored");
  endtask

  task automatic test_big_addresses();
    localparam int PER  = B_NIN + 3;
    localparam int BASE = 9 * PER + 1;
    localparam int DONE_CYC = B_NOUT * PER + 1;
    int addr_bad = 0;
    int res_cnt  = 0;
    int done_cnt = 0;
    for (int n = 0; n < B_NOUT; n++) push_exp(n, big_model(n), (n + 1) * PER);
    @(negedge clk);
    b_start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 4; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (c >= BASE && c < BASE + B_NIN) begin
        total++;
        if (int'(b_in_addr) != c - BASE || int'(b_w_addr) != 28224 + c - BASE || b_b_addr !== 4'd9) begin
          bad++; addr_bad++;
          if (addr_bad <= 5)
            $display("FAIL big_addr c=%0d: got ia=%0d wa=%0d ba=%0d expected ia=%0d wa=%0d ba=9",
                     c, b_in_addr, b_w_addr, b_b_addr, c - BASE, 28224 + c - BASE);
        end
      end
      if (b_out_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL big_extra_result c=%0d: got idx=%0d expected none", c, b_out_idx);
        end else begin
          if (b_out_idx !== sb[0].idx || b_out_data !== sb[0].data || c != sb[0].cyc) begin
            bad++; $display("FAIL big_result: got idx=%0d data=%0d c=%0d expected idx=%0d data=%0d c=%0d",
                            b_out_idx, b_out_data, c, sb[0].idx, sb[0].data, sb[0].cyc);
          end
          void'(sb.pop_front());
          res_cnt++;
        end
      end
      if (b_done === 1'b1) begin
        done_cnt++;
        total++;
        if (c != DONE_CYC) begin
          bad++; $display("FAIL big_done_cycle: got %0d expected %0d", c, DONE_CYC);
        end
      end
    end
    total++;
    if (res_cnt != B_NOUT || done_cnt != 1) begin
      bad++; $display("FAIL big_counts: got results=%0d dones=%0d expected %0d/1", res_cnt, done_cnt, B_NOUT);
    end
    sb.delete();
  endtask

  initial begin
    load_basic();
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_reset_midpass();
    test_start_ignored();
    test_big_addresses();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Sequences one fully-connected layer as a single time-shared MAC: for each output neuron n it streams N_IN activation/weight pairs from synchronous memories, then adds the bias and emits one result.
- Sits between the pooled feature-map buffer (activation memory), the weight/bias ROMs and the next layer or argmax stage.
- It replaces a fully parallel dot product with N_IN+3 cycles per neuron.

Parameters:
- N_IN, 3136, inputs per neuron (dot-product length)
- N_OUT, 10, output neurons per layer
- IN_W, 30, signed activation width
- W_W, 9, signed weight and bias width
- ACC_W, 38, signed accumulator and result width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- in_addr  out  clog2(N_IN)  activation read address
- in_data  in  IN_W  signed activation; valid 1 cycle after in_addr
- w_addr  out  clog2(N_IN*N_OUT)  weight read address, n*N_IN+k
- w_data  in  W_W  signed weight; valid 1 cycle after w_addr
- b_addr  out  clog2(N_OUT)  bias read address, equal to n
- b_data  in  W_W  signed bias; valid 1 cycle after b_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACC_W  signed neuron result
- out_idx  out  clog2(N_OUT)  neuron index of out_data
- done  out  1  one-cycle pulse when the layer pass completes

Behaviour:
- Reset (async, rst=1):
  - state goes to IDLE.
  - All outputs are 0: busy, out_valid, done, out_data, out_idx, in_addr, w_addr, b_addr.
  - Accumulator, bias register, k and n are cleared.
  - Reset mid-pass aborts the pass; no out_valid or done is produced afterwards.
- States: IDLE, MAC, DRAIN, BIAS, WRITE, DONE.
- IDLE:
  - On start=1: n=0, k=0, acc=0, go to MAC.
  - Otherwise stay in IDLE.
- MAC (N_IN cycles):
  - Each cycle drives in_addr=k and w_addr=n*N_IN+k, then k++.
  - b_addr=n is driven throughout; the bias register captures b_data in the cycle after k=0.
  - From the second MAC cycle on, acc += in_data*w_data (data from the previous cycle's address).
  - After k=N_IN-1 is issued, go to DRAIN.
- DRAIN (1 cycle): accumulates the last product.
- BIAS (1 cycle): acc += sign-extended bias.
- WRITE:
  - out_valid=1, out_data=acc, out_idx=n. These are registered and stable while out_ready=0.
  - On out_valid && out_ready:
    - if n<N_OUT-1: n++, k=0, acc=0, go to MAC;
    - else go to DONE.
- DONE (1 cycle): done=1, busy=0 in this cycle, then IDLE.
- Arithmetic:
  - Product is IN_W+W_W bits signed, sign-extended or truncated to ACC_W.
  - All accumulation is two's-complement modulo 2^ACC_W: no saturation, no overflow flag.
- Timing:
  - With start sampled at cycle 0 and out_ready held high, neuron n's out_valid rises at cycle (n+1)*(N_IN+3).
  - done pulses at cycle N_OUT*(N_IN+3)+1.
- start is ignored outside IDLE.
- start held high in IDLE after DONE starts a new pass immediately.
- Address outputs hold their last value outside MAC; memory reads there are don't-care.

Test Plan:
- N_IN=4, N_OUT=2; in=[1,2,3,4]; w0=[1,1,1,1], b0=5; w1=[-1,2,-3,4], b1=-2; out_ready=1; start pulse at cycle 0 -> out_valid at cycle 7 (out_idx=0, out_data=15), at cycle 14 (out_idx=1, out_data=8), done pulse at cycle 15, busy high for cycles 1–14.
- Backpressure: same stimulus, out_ready=0 for 5 cycles from cycle 7 -> out_valid and out_data=15 held through cycle 11, accepted at cycle 12, second result at cycle 19, done at cycle 20.
- Wrap-around: N_IN=4, all in=-2^29, all w=-256, bias 0 -> sum 2^39 mod 2^38, out_data=0.
- Reset mid-pass: assert rst asynchronously at cycle 3 -> all outputs 0 immediately, no out_valid or done follows; a new start then gives the first scenario's results with the same timing.
- start pulses at cycles 2 and 9 during a pass -> ignored; exactly 2 results and 1 done produced.
- Address check, defaults N_IN=3136, N_OUT=10: for neuron 9, w_addr runs 28224..31359 and in_addr runs 0..3135, b_addr=9.
